instr_fetch_ctrl: RTL and testbench

- Fetch/sequencing stage that sits directly around the 19-bit program counter.
- Reads the current PC, requests the instruction from instruction memory over a req/valid handshake, and hands it to decode over a valid/ready handshake.
- Decodes control-flow opcodes and drives exactly one single-cycle PC control strobe (update/branch/call/ret/jump), plus the PC's next-sequential input and jump address.
- Halts on HLT.

---
 rtl/instr_fetch_ctrl_pkg.sv | 20 ++
 rtl/instr_fetch_ctrl_cf_decode.sv | 23 ++
 rtl/instr_fetch_ctrl.sv | 98 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared widths, opcode constants and FSM state encoding for the fetch stage
package instr_fetch_ctrl_pkg;
  localparam int DATA_W      = 19;
  localparam int OPC_W       = 5;
  localparam int ADDR_FLD_W  = 14;
  localparam int STACK_DEPTH = 16;
  localparam logic [OPC_W-1:0] OPC_JMP  = 5'h10;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 5'h11;
  localparam logic [OPC_W-1:0] OPC_BNE  = 5'h12;
  localparam logic [OPC_W-1:0] OPC_CALL = 5'h13;
  localparam logic [OPC_W-1:0] OPC_RET  = 5'h14;
  localparam logic [OPC_W-1:0] OPC_HLT  = 5'h1F;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_REQ    = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_ISSUE  = 3'd3;
  localparam state_t S_UPDATE = 3'd4;
  localparam state_t S_HALT   = 3'd5;
endpackage

// File: rtl/instr_fetch_ctrl_cf_decode.sv
// cf_decode: combinational control-flow decode of opcode + zero flag into a PC strobe one-hot
// Ports: opc_i opcode, zero_i ALU zero flag,
//        sel_o strobe one-hot {jump,ret,call,branch,update}, seq_o sequential advance, hlt_o halt
module cf_decode
  import instr_fetch_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  input  logic             zero_i,
  output logic [4:0]       sel_o,
  output logic             seq_o,
  output logic             hlt_o
);
  always_comb begin
    hlt_o = opc_i == OPC_HLT;
    sel_o = opc_i == OPC_JMP  ? 5'b10000 :
            opc_i == OPC_BEQ  ? (zero_i ? 5'b00010 : 5'b00001) :
            opc_i == OPC_BNE  ? (zero_i ? 5'b00001 : 5'b00010) :
            opc_i == OPC_CALL ? 5'b00100 :
            opc_i == OPC_RET  ? 5'b01000 :
            hlt_o             ? 5'b00000 : 5'b00001;
    seq_o = sel_o[0];
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch/sequencing FSM around the program counter, driving one PC strobe per instruction
// Ports: clk/reset (async, active-high); pc_in, zero_flag from datapath;
//        imem_req/imem_addr/imem_valid/imem_rdata instruction-memory handshake;
//        instr_valid/instr_ready/instr_out decode handshake;
//        pc_update/pc_branch/pc_call/pc_ret/pc_jump, pc_next, jump_addr PC control; halted, fault status.
// Optional: CALL_DEPTH_CHECK_EN adds a call-depth counter that faults on stack over/underflow.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              zero_flag,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic              pc_update,
  output logic              pc_branch,
  output logic              pc_call,
  output logic              pc_ret,
  output logic              pc_jump,
  output logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] jump_addr,
  output logic              halted,
  output logic              fault
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] instr_q, jaddr_q;
  logic [4:0] sel_q, sel_d;
  logic seq_q, seq_d, hlt_q, hlt_d;
  logic upd, hs, bad;
  cf_decode u_dec (
    .opc_i (instr_q[DATA_W-1 -: OPC_W]),
    .zero_i(zero_flag),
    .sel_o (sel_d),
    .seq_o (seq_d),
    .hlt_o (hlt_d)
  );
  assign upd = state_q == S_UPDATE;
  assign hs  = state_q == S_ISSUE && instr_ready;
  assign {pc_jump, pc_ret, pc_call, pc_branch, pc_update} = (upd && !bad) ? sel_q : 5'b0;
  assign pc_next     = pc_in + DATA_W'(upd && seq_q);
  assign imem_req    = state_q == S_REQ;
  assign imem_addr   = pc_in;
  assign instr_valid = state_q == S_ISSUE;
  assign instr_out   = instr_q;
  assign jump_addr   = jaddr_q;
  assign halted      = state_q == S_HALT;
  always_comb begin
    state_d = state_q == S_IDLE   ? S_REQ :
              state_q == S_REQ    ? S_WAIT :
              state_q == S_WAIT   ? (imem_valid ? S_ISSUE : S_WAIT) :
              state_q == S_ISSUE  ? (instr_ready ? S_UPDATE : S_ISSUE) :
              state_q == S_UPDATE ? ((hlt_q || bad) ? S_HALT : S_REQ) : S_HALT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      jaddr_q <= '0;
      sel_q   <= '0;
      seq_q   <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT && imem_valid) instr_q <= imem_rdata;
      if (hs) begin
        sel_q   <= sel_d;
        seq_q   <= seq_d;
        hlt_q   <= hlt_d;
        jaddr_q <= {{(DATA_W-ADDR_FLD_W){1'b0}}, instr_q[ADDR_FLD_W-1:0]};
      end
    end
  end
`ifdef CALL_DEPTH_CHECK_EN
  logic [4:0] depth_q;
  logic fault_q;
  // Overflowing CALL or underflowing RET is caught in UPDATE, before any strobe reaches the PC.
  assign bad   = upd && ((sel_q[2] && depth_q == 5'(STACK_DEPTH)) || (sel_q[3] && depth_q == 5'd0));
  assign fault = fault_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      depth_q <= depth_q + 5'(pc_call) - 5'(pc_ret);
      fault_q <= fault_q | bad;
    end
  end
`else
  assign bad   = 1'b0;
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized self-checking bench with a transaction-level timing model of the fetch stage
module tb_instr_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [18:0] pc_in = '0, imem_rdata = '0;
  logic zero_flag = 1'b0, imem_valid = 1'b0, instr_ready = 1'b0;
  logic imem_req, instr_valid, pc_update, pc_branch, pc_call, pc_ret, pc_jump, halted, fault;
  logic [18:0] imem_addr, instr_out, pc_next, jump_addr;
  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .zero_flag(zero_flag),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .pc_update(pc_update), .pc_branch(pc_branch), .pc_call(pc_call), .pc_ret(pc_ret), .pc_jump(pc_jump),
    .pc_next(pc_next), .jump_addr(jump_addr), .halted(halted), .fault(fault)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0, depth = 0;
  bit chk_en = 1'b0;
  logic e_req, e_iv, e_halt, e_fault, m_halt, m_fault;
  logic [4:0] e_stb;
  logic [18:0] e_addr, e_iout, e_nx, e_ja, m_iout, m_ja;
  task automatic chk(string n, logic [18:0] a, logic [18:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    chk("instr_valid", instr_valid, e_iv);
    chk("instr_out", instr_out, e_iout);
    chk("strobes", {pc_jump, pc_ret, pc_call, pc_branch, pc_update}, e_stb);
    chk("strobe_onehot0", $onehot0({pc_jump, pc_ret, pc_call, pc_branch, pc_update}), 1);
    chk("pc_next", pc_next, e_nx);
    chk("jump_addr", jump_addr, e_ja);
    chk("halted", halted, e_halt);
    chk("fault", fault, e_fault);
  end
  function automatic logic [4:0] model_stb(logic [4:0] opc, logic zf);
    case (opc)
      5'h10: return 5'b10000;
      5'h11: return zf ? 5'b00010 : 5'b00001;
      5'h12: return zf ? 5'b00001 : 5'b00010;
      5'h13: return 5'b00100;
      5'h14: return 5'b01000;
      5'h1F: return 5'b00000;
      default: return 5'b00001;
    endcase
  endfunction
  task automatic base();
    e_req = 0; e_iv = 0; e_stb = 0; e_addr = pc_in; e_nx = pc_in;
    e_iout = m_iout; e_ja = m_ja; e_halt = m_halt; e_fault = m_fault;
  endtask
  task automatic cyc();
    @(posedge clk); #1;
    imem_valid = 1'($urandom); imem_rdata = 19'($urandom); zero_flag = 1'($urandom); instr_ready = 1'($urandom);
  endtask
  task automatic do_reset();
    reset = 1; m_iout = 0; m_ja = 0; depth = 0; m_halt = 0; m_fault = 0; pc_in = 0;
    base();
    repeat (2) begin cyc(); pc_in = 0; base(); end
    cyc(); reset = 0; imem_valid = 1; imem_rdata = 19'h7FFFF; pc_in = 0;
    base();
  endtask
  task automatic run(logic [18:0] ins, logic [18:0] pc, int lat, int rdy, logic zf, int rst_at, int pin);
    logic [4:0] stb;
    logic bad;
    cyc(); pc_in = pc; base(); e_req = 1; e_addr = pc;
    for (int i = 0; i <= lat; i++) begin
      cyc(); pc_in = pc; imem_valid = (i == lat);
      if (i == lat) imem_rdata = ins;
      base();
    end
    m_iout = ins;
    for (int i = 0; i <= rdy; i++) begin
      cyc(); pc_in = pc; instr_ready = (i == rdy);
      if (i == rdy) zero_flag = zf;
      if (i == rst_at) begin
        instr_ready = 0;
        do_reset();
        return;
      end
      base(); e_iv = 1;
    end
    m_ja = {5'b0, ins[13:0]};
    cyc(); pc_in = pc; base();
    stb = model_stb(ins[18:14], zf);
    bad = 0;
`ifdef CALL_DEPTH_CHECK_EN
    bad = (stb[2] && depth == 16) || (stb[3] && depth == 0);
`endif
    if (bad) stb = 0;
    depth = depth + int'(stb[2]) - int'(stb[3]);
    e_stb = stb;
    e_nx = pc + 19'(stb[0]);
    if (pin >= 0) begin @(negedge clk); chk("pin_pc_next", pc_next, pin[18:0]); end
    if (ins[18:14] == 5'h1F || bad) begin
      m_halt = 1; m_fault = m_fault | bad;
      repeat (3) begin cyc(); base(); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    logic [4:0] opc;
    int r;
    repeat (2) @(posedge clk);
    #1; chk_en = 1;
    do_reset();
    run(19'h00000, 19'h00000, 3, 0, 0, -1, 1);
    run(19'h40123, 19'h00050, 1, 0, 0, -1, -1);
    chk("pin_jmp_addr", jump_addr, 19'h00123);
    run(19'h44200, 19'h00100, 0, 1, 0, -1, 19'h00101);
    run(19'h44200, 19'h00100, 2, 0, 1, -1, 19'h00100);
    chk("pin_beq_target", jump_addr, 19'h00200);
    run(19'h0ABCD, 19'h7FFFF, 0, 0, 0, -1, 0);
    run(19'h48077, 19'h00200, 0, 0, 0, -1, -1);
    run(19'h48077, 19'h00200, 0, 0, 1, -1, 19'h00201);
    run(19'h4C300, 19'h00210, 1, 1, 0, -1, -1);
    run(19'h50000, 19'h00300, 1, 1, 0, -1, -1);
    run(19'h0ABCD, 19'h00010, 0, 5, 0, 2, -1);
    chk("pin_abort_instr_out", instr_out, 19'h00000);
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 7);
      opc = r < 6 ? 5'(5'h10 + r) : r == 6 ? 5'($urandom_range(0, 15)) : 5'($urandom);
      run({opc, 14'($urandom)}, 19'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), -1, -1);
      if (m_halt) do_reset();
    end
    run(19'h7C000, 19'h00400, 0, 0, 0, -1, -1);
    chk("pin_halted", halted, 1);
    do_reset();
`ifdef CALL_DEPTH_CHECK_EN
    repeat (16) run(19'h4C010, 19'h00020, 0, 0, 0, -1, -1);
    run(19'h4C010, 19'h00020, 0, 0, 0, -1, -1);
    chk("pin_call_fault", fault, 1);
    chk("pin_call_halted", halted, 1);
    do_reset();
    run(19'h50000, 19'h00030, 0, 0, 0, -1, -1);
    chk("pin_ret_fault", fault, 1);
    do_reset();
`endif
    run(19'h00001, 19'h00005, 0, 0, 0, -1, 19'h00006);
    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
